// File: rtl/charlieplex_pkg.sv
// Shared definitions for the charlieplexed LED driver and key scanner.
package charlieplex_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    EVAL
  } scan_state_t;

  // Column x drives, row y senses; the diagonal x == y does not exist.
  function automatic int unsigned led_index(input int unsigned x,
                                            input int unsigned y,
                                            input int unsigned pincount);
    return (x > y) ? (pincount - 1) * x + y : (pincount - 1) * x + y - 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs, parameterized width.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/charlieplex_keyscan.sv
// Charlieplexed key matrix scanner: drives one pin at a time, debounces each
// key across frames and reports press/release events over valid/ready.
module charlieplex_keyscan
  import charlieplex_pkg::*;
#(
  parameter int unsigned PINCOUNT       = 4,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned DEBOUNCE_SCANS = 3,
  localparam int unsigned KEYCOUNT      = PINCOUNT * (PINCOUNT - 1),
  localparam int unsigned INDEXBITS     = $clog2(KEYCOUNT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [PINCOUNT-1:0]  pins_in,
  output logic [PINCOUNT-1:0]  out_en,
  output logic [PINCOUNT-1:0]  out_value,
  output logic [KEYCOUNT-1:0]  key_state,
  output logic                 event_valid,
  input  logic                 event_ready,
  output logic [INDEXBITS-1:0] event_key,
  output logic                 event_pressed,
  output logic                 scan_done
);

  localparam int unsigned PW = $clog2(PINCOUNT);
  localparam int unsigned SW = $clog2(SETTLE_CYCLES);
  localparam int unsigned CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [PW-1:0] LAST_PIN    = PW'(PINCOUNT - 1);
  localparam logic [SW-1:0] LAST_SETTLE = SW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] THRESH      = CW'(DEBOUNCE_SCANS - 1);

  logic [PINCOUNT-1:0]  pins_sync;
  logic [PINCOUNT-1:0]  sample;
  scan_state_t          state;
  logic [PW-1:0]        d;
  logic [PW-1:0]        y;
  logic [PW-1:0]        next_d;
  logic [SW-1:0]        settle;
  logic [CW-1:0]        cnt [KEYCOUNT];
  logic [INDEXBITS-1:0] k;
  logic                 raw;
  logic                 same;
  logic                 at_thresh;
  logic                 flip;
  logic                 stall;

  sync_2ff #(.WIDTH(PINCOUNT)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pins_in),
    .q     (pins_sync)
  );

  always_comb begin
    k         = INDEXBITS'(led_index(32'(d), 32'(y), PINCOUNT));
    raw       = sample[y];
    same      = (raw == key_state[k]);
    at_thresh = (cnt[k] >= THRESH);
    flip      = (state == EVAL) && (y != d) && !same && at_thresh;
    // A flip with the event slot still occupied freezes the whole EVAL step.
    stall     = flip && event_valid && !event_ready;
    next_d    = (d == LAST_PIN) ? '0 : d + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      d             <= '0;
      y             <= '0;
      settle        <= '0;
      sample        <= '0;
      out_en        <= '0;
      out_value     <= '0;
      key_state     <= '0;
      event_valid   <= 1'b0;
      event_key     <= '0;
      event_pressed <= 1'b0;
      scan_done     <= 1'b0;
      for (int unsigned i = 0; i < KEYCOUNT; i++) cnt[i] <= '0;
    end else begin
      scan_done <= 1'b0;
      if (event_valid && event_ready) event_valid <= 1'b0;

      if (!enable) begin
        state     <= IDLE;
        out_en    <= '0;
        out_value <= '0;
      end else begin
        case (state)
          IDLE: begin
            state     <= DRIVE;
            d         <= '0;
            settle    <= '0;
            out_en    <= PINCOUNT'(1);
            out_value <= PINCOUNT'(1);
          end
          DRIVE: begin
            if (settle == LAST_SETTLE) state <= SAMPLE;
            else settle <= settle + SW'(1);
          end
          SAMPLE: begin
            sample    <= pins_sync;
            y         <= '0;
            state     <= EVAL;
            out_en    <= '0;
            out_value <= '0;
          end
          EVAL: begin
            if (!stall) begin
              if (y != d) begin
                if (same) begin
                  cnt[k] <= '0;
                end else if (!at_thresh) begin
                  cnt[k] <= cnt[k] + CW'(1);
                end else begin
                  key_state[k]  <= raw;
                  cnt[k]        <= '0;
                  event_key     <= k;
                  event_pressed <= raw;
                  event_valid   <= 1'b1;
                end
              end
              if (y == LAST_PIN) begin
                d         <= next_d;
                scan_done <= (d == LAST_PIN);
                settle    <= '0;
                state     <= DRIVE;
                out_en    <= PINCOUNT'(1) << next_d;
                out_value <= PINCOUNT'(1) << next_d;
              end else begin
                y <= y + PW'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_charlieplex_keyscan.sv
// Self-checking bench for charlieplex_keyscan: frame-level debounce model feeds
// an event scoreboard, plus directed checks of timing, stall, enable and reset.
module tb_charlieplex_keyscan;

  localparam int unsigned P   = 4;
  localparam int unsigned K   = 12;
  localparam int unsigned DEB = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        event_ready = 1'b1;
  logic [3:0]  pins_in;
  logic [3:0]  out_en;
  logic [3:0]  out_value;
  logic [11:0] key_state;
  logic        event_valid;
  logic [3:0]  event_key;
  logic        event_pressed;
  logic        scan_done;

  logic [11:0] tb_keys = '0;
  int unsigned n_tests = 0;
  int unsigned n_fail = 0;
  logic [4:0]  evq [$];
  logic [4:0]  ev_exp;
  logic        tb_state [K];
  int unsigned tb_cnt [K];

  always #5 clk = ~clk;

  charlieplex_keyscan #(
    .PINCOUNT       (P),
    .SETTLE_CYCLES  (4),
    .DEBOUNCE_SCANS (DEB)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .pins_in       (pins_in),
    .out_en        (out_en),
    .out_value     (out_value),
    .key_state     (key_state),
    .event_valid   (event_valid),
    .event_ready   (event_ready),
    .event_key     (event_key),
    .event_pressed (event_pressed),
    .scan_done     (scan_done)
  );

  function automatic int unsigned tb_idx(input int unsigned x, input int unsigned y);
    if (x > y) return 3 * x + y;
    return 3 * x + y - 1;
  endfunction

  // Pad model: a driven-high column pulls its own pin and every pressed row.
  always_comb begin
    pins_in = '0;
    for (int x = 0; x < 4; x++) begin
      if (out_en[x] && out_value[x]) begin
        for (int y = 0; y < 4; y++) begin
          if (y == x) pins_in[y] = 1'b1;
          else if (tb_keys[tb_idx(x, y)]) pins_in[y] = 1'b1;
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < K; i++) begin
      tb_state[i] = 1'b0;
      tb_cnt[i]   = 0;
    end
    evq.delete();
  endtask

  task automatic model_frame(input logic [11:0] keys);
    int unsigned kk;
    logic raw;
    for (int dd = 0; dd < 4; dd++) begin
      for (int yy = 0; yy < 4; yy++) begin
        if (yy != dd) begin
          kk  = tb_idx(dd, yy);
          raw = keys[kk];
          if (raw == tb_state[kk]) tb_cnt[kk] = 0;
          else if (tb_cnt[kk] < DEB - 1) tb_cnt[kk]++;
          else begin
            tb_state[kk] = raw;
            tb_cnt[kk]   = 0;
            evq.push_back({raw, 4'(kk)});
          end
        end
      end
    end
  endtask

  task automatic wait_done(output int unsigned cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!scan_done && cyc < 300);
    if (!scan_done) check_eq("done_timeout", 32'(scan_done), 1);
  endtask

  task automatic wait_valid(inout int unsigned cyc);
    int unsigned n = 0;
    do begin
      @(negedge clk);
      cyc++;
      n++;
    end while (!event_valid && n < 300);
    if (!event_valid) check_eq("valid_timeout", 32'(event_valid), 1);
  endtask

  task automatic do_frame(input logic [11:0] keys, output int unsigned cyc);
    tb_keys = keys;
    model_frame(keys);
    wait_done(cyc);
  endtask

  always @(posedge clk) begin
    if (rst_n && event_valid && event_ready) begin
      if (evq.size() == 0) check_eq("ev_unexpected", 32'(evq.size()), 1);
      else begin
        ev_exp = evq.pop_front();
        check_eq("ev", {event_pressed, event_key}, ev_exp);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) check_eq("onehot0", 32'($countones(out_en) <= 1), 1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned cyc;
    int unsigned total;
    logic bad;

    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("idle_out_en", out_en, 0);
    check_eq("idle_key_state", key_state, 0);
    check_eq("idle_valid", event_valid, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_out_en", out_en, 0);
    check_eq("rst_done", scan_done, 0);

    // Column sequencing right after enable.
    tb_keys = '0;
    model_frame('0);
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("drive_seq", out_en, (i < 5) ? 1 : ((i < 9) ? 0 : 2));
    end
    check_eq("out_value", out_value, 4'b0010);
    wait_done(cyc);
    do_frame('0, cyc);
    check_eq("frame_len", cyc, 36);

    // Key 4 press then release.
    do_frame(12'h010, cyc);
    do_frame(12'h010, cyc);
    check_eq("ks_press_2", key_state, 12'h000);
    do_frame(12'h010, cyc);
    check_eq("ks_press_3", key_state, 12'h010);
    do_frame('0, cyc);
    do_frame('0, cyc);
    check_eq("ks_rel_2", key_state, 12'h010);
    do_frame('0, cyc);
    check_eq("ks_rel_3", key_state, 12'h000);

    // Bounce on key 9.
    do_frame(12'h200, cyc);
    do_frame(12'h200, cyc);
    do_frame('0, cyc);
    do_frame(12'h200, cyc);
    do_frame(12'h200, cyc);
    check_eq("bounce_hold", key_state, 12'h000);
    do_frame(12'h200, cyc);
    check_eq("bounce_flip", key_state, 12'h200);
    repeat (3) do_frame('0, cyc);
    check_eq("bounce_rel", key_state, 12'h000);

    // Backpressure: keys 0 and 11 flip in the same frame.
    event_ready = 1'b0;
    do_frame(12'h801, cyc);
    do_frame(12'h801, cyc);
    model_frame(12'h801);
    cyc = 0;
    wait_valid(cyc);
    check_eq("bp_first_key", {event_pressed, event_key}, 5'h10);
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      cyc++;
      if (event_key !== 4'd0 || event_valid !== 1'b1 || scan_done !== 1'b0) bad = 1'b1;
    end
    check_eq("bp_hold", bad, 0);
    check_eq("bp_stall_out_en", out_en, 0);
    event_ready = 1'b1;
    @(negedge clk);
    cyc++;
    check_eq("bp_back2back", {event_valid, event_key}, 5'h1b);
    wait_done(total);
    cyc += total;
    check_eq("bp_frame_long", 32'(cyc > 36), 1);
    repeat (3) do_frame('0, cyc);
    check_eq("bp_rel", key_state, 12'h000);

    // Enable dropped during DRIVE with an event pending.
    event_ready = 1'b0;
    repeat (3) do_frame(12'h008, cyc);
    check_eq("en_pending", {event_valid, event_pressed, event_key}, 6'h33);
    enable = 1'b0;
    @(negedge clk);
    check_eq("en_drop_out_en", out_en, 0);
    check_eq("en_drop_event", {event_valid, event_key}, 5'h13);
    repeat (5) @(negedge clk);
    check_eq("en_idle_out_en", out_en, 0);
    enable = 1'b1;
    @(negedge clk);
    check_eq("en_resume", out_en, 4'b0001);
    event_ready = 1'b1;
    model_frame(12'h008);
    wait_done(cyc);
    check_eq("en_q_empty", 32'(evq.size()), 0);
    check_eq("en_ks", key_state, 12'h008);

    // Reset while a release event is pending mid-EVAL.
    do_frame('0, cyc);
    do_frame('0, cyc);
    event_ready = 1'b0;
    tb_keys = '0;
    cyc = 0;
    wait_valid(cyc);
    check_eq("rs_pending", {event_pressed, event_key}, 5'h03);
    rst_n = 1'b0;
    #1;
    check_eq("rs_out_en", out_en, 0);
    check_eq("rs_valid", event_valid, 0);
    check_eq("rs_ks", key_state, 0);
    check_eq("rs_fields", {event_pressed, event_key, scan_done}, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    event_ready = 1'b1;
    @(negedge clk);
    check_eq("rs_restart", out_en, 4'b0001);
    model_frame('0);
    wait_done(cyc);
    check_eq("final_q_empty", 32'(evq.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/charlieplex_keyscan.md
Name: charlieplex_keyscan

Overview:
- Scans a charlieplexed switch matrix of PINCOUNT*(PINCOUNT-1) keys over PINCOUNT tristateable pins. This is the input-side counterpart of the charlieplexed LED driver.
- Drives one pin high at a time, samples the other pins, debounces each key and emits press/release events over a valid/ready handshake.
- Sits between the tristate pad cells and the application logic.
- Matrix topology and key indexing are identical to the LED matrix:
  - Key at column x, row y, with x != y, has index (PINCOUNT-1)*x + y when x > y, else (PINCOUNT-1)*x + y - 1.
  - Each key has a series diode from column pin x (driven high) to row pin y (sensed, with an external pull-down).

Parameters:
- PINCOUNT, 4, number of matrix pins (>= 2).
- SETTLE_CYCLES, 4, cycles a column is driven before sampling (>= 3; covers the 2-FF synchronizer plus pad settling).
- DEBOUNCE_SCANS, 3, consecutive frames a key's raw value must differ from its debounced state before the state flips (>= 1).
- KEYCOUNT (localparam), PINCOUNT*(PINCOUNT-1).
- INDEXBITS (localparam), $clog2(KEYCOUNT).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  scan enable
- pins_in  input  PINCOUNT  raw pad input values (asynchronous)
- out_en  output  PINCOUNT  drive-enable per pin; 0 = tristate
- out_value  output  PINCOUNT  drive value for enabled pins
- key_state  output  KEYCOUNT  debounced key state, 1 = pressed
- event_valid  output  1  an event is pending
- event_ready  input  1  consumer accepts the event
- event_key  output  INDEXBITS  index of the key that changed
- event_pressed  output  1  1 = press, 0 = release
- scan_done  output  1  one-cycle pulse at the end of each full frame

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - out_en = 0, out_value = 0, key_state = 0, all debounce counters = 0.
  - event_valid = 0, event_key = 0, event_pressed = 0, scan_done = 0.
  - State = IDLE, drive index d = 0.
- Input path: pins_in passes through a 2-FF synchronizer (reset to 0) before any use.
- State machine:
  - IDLE: out_en = 0. When enable = 1, go to DRIVE with d = 0 and the settle counter at 0.
  - DRIVE: out_en = one-hot(d), out_value = one-hot(d). Stay SETTLE_CYCLES cycles, then go to SAMPLE.
  - SAMPLE: still driving. Latch the synchronized pins into a sample register. Next state EVAL with y = 0.
  - EVAL: out_en = 0. Visits y = 0 .. PINCOUNT-1, one per cycle; y = d is a no-op. For each y != d:
    - k = index(d, y), raw = sample[y].
    - If raw == key_state[k]: cnt[k] <= 0.
    - Else if cnt[k] < DEBOUNCE_SCANS-1: cnt[k] <= cnt[k] + 1.
    - Else (flip): key_state[k] <= raw, cnt[k] <= 0, load event register with event_key = k, event_pressed = raw, event_valid = 1.
    - After y = PINCOUNT-1: if d == PINCOUNT-1, set d = 0 and pulse scan_done. Otherwise d = d + 1. Next state DRIVE.
- Unstalled frame length: PINCOUNT*(SETTLE_CYCLES+1+PINCOUNT) cycles, i.e. 36 at the defaults.
- Event handshake:
  - An event transfers when event_valid && event_ready. event_valid clears the cycle after transfer unless a new event loads in that same cycle.
  - Stall: if a flip is required while event_valid && !event_ready, EVAL holds y. No counter or state update occurs and no event is lost.
  - A flip coinciding with a transfer loads the new event directly, so back-to-back events have no bubble.
  - event_key and event_pressed stay stable while event_valid && !event_ready.
- Debounce counter width is $clog2(DEBOUNCE_SCANS+1). Counter reaching DEBOUNCE_SCANS-1 is the flip threshold, so DEBOUNCE_SCANS = 1 flips on the first mismatch.
- enable deasserted in any state:
  - Next edge goes to IDLE and out_en drops to 0; any EVAL stall is abandoned.
  - key_state, counters and any pending event are retained.
  - Re-enable restarts at d = 0.
- Reset asserted mid-frame: all outputs return to reset values immediately, including a pending event, which is discarded.
- Never more than one out_en bit is set.

Decomposition:
- Shared package charlieplex_pkg holds:
  - the led_index(x, y, pincount) function, also used by the LED driver;
  - the scan state enumeration (IDLE, DRIVE, SAMPLE, EVAL).
- One sub-module: sync_2ff, a parameterized-width 2-flop synchronizer with asynchronous active-low reset.
- The debounce counters are a flat array in the top level; only one key is updated per cycle.

Test Plan:
- Reset and idle (enable = 0, then rst_n pulse) -> out_en = 0, key_state = 0, event_valid = 0. enable = 1 -> out_en = 4'b0001 for 5 cycles, then 0 for 4 cycles, then 4'b0010; scan_done every 36 cycles.
- Press key 4 (pins_in[2] = 1 whenever out_en == 4'b0010) -> event_valid = 1 with event_key = 4, event_pressed = 1 during the 3rd frame; key_state = 12'h010. Release -> event with event_pressed = 0 three frames later.
- Bounce: key 9 (x=3, y=0) present for 2 frames, absent for 1, then present -> no event until 3 consecutive present frames.
- Backpressure: event_ready = 0, keys 0 and 11 flip in the same frame -> key 0 event held stable and scan stalls in EVAL. Raise event_ready -> key 0 then key 11 delivered back-to-back; frame is lengthened by the stall.
- enable dropped during DRIVE with an event pending -> out_en = 0 next cycle, event retained. Re-enable -> scan resumes with out_en = 4'b0001.
- rst_n asserted mid-EVAL with event_valid = 1 -> all outputs 0 asynchronously; scan restarts from pin 0 after release.
